img_frame_sequencer: RTL and testbench
======================================

// Module: img_frame_sequencer
// PURPOSE
//  Frame-level controller in front of img_preproc_top on the DE1-SoC data path. Parses a
//  2-word host header, meters exactly the payload word count into the preprocessor, and
//  forwards the expected number of result words downstream. Closes each frame with a
//  status word, so host software sees frame boundaries, overruns and hangs.
// PARAMETERS
//  PIX_PER_WORD  4        pixels packed per 32b payload word (power of 2)
//  MAX_WORDS     65536    max payload words per frame; larger headers are rejected
//  TIMEOUT       4096     idle cycles allowed in DRAIN before watchdog error
// PORTS
//  clock             in   1   single clock domain
//  reset             in   1   asynchronous, active-high
//  in_data           in   32  host word (header or payload)
//  in_valid          in   1   host word valid
//  upstream_stall    out  1   back-pressure to host
//  pp_in_data        out  32  payload word to preprocessor
//  pp_in_valid       out  1   payload valid to preprocessor
//  pp_in_stall       in   1   preprocessor upstream_stall
//  pp_out_data       in   32  preprocessor result word
//  pp_out_valid      in   1   result valid
//  pp_out_stall      out  1   back-pressure to preprocessor
//  out_data          out  32  result/status word downstream
//  out_valid         out  1   downstream valid
//  downstream_stall  in   1   downstream back-pressure
//  busy              out  1   high in any state except IDLE
//  frame_count       out  16  frames completed (wraps 0xFFFF->0)
// BEHAVIOUR
//  - Transfer rule on every link: word moves in the cycle where valid=1 and stall=0.
//  - Reset (async): state=IDLE; out_valid=0, out_data=0, frame_count=0; all counters and
//    error flags cleared. Reset mid-frame drops the frame silently; no status word.
//  - FSM: IDLE -> HDR1 -> LOAD -> DRAIN -> STATUS -> IDLE.
//  - IDLE: accepts word0 = {width[31:16], height[15:0]}.
//  - HDR1: accepts word1 = expected result word count N_OUT.
//  - Payload words N_IN = ceil(width*height / PIX_PER_WORD). Use a 32b product.
//  - Header rejection: width==0, height==0, N_IN>MAX_WORDS or N_OUT==0 sets err_hdr.
//    FSM then goes HDR1 -> STATUS directly. The host must send no payload.
//  - In IDLE/HDR1, upstream_stall=0. In LOAD, upstream_stall=pp_in_stall, and pp_in_* is a
//    combinational pass-through of in_*. Outside LOAD, pp_in_valid=0.
//  - In DRAIN/STATUS, upstream_stall=1.
//  - LOAD -> DRAIN on the cycle the N_IN-th payload word transfers.
//  - Result path is enabled in LOAD and DRAIN while out_cnt<N_OUT, so outputs may overlap
//    loading.
//  - Otherwise pp_out_stall=1; surplus/early results are held, never dropped.
//  - Output register: out_data/out_valid is a 1-entry register, loaded when
//    !(out_valid && downstream_stall).
//    pp_out_stall = !enable | (out_valid & downstream_stall). Latency from pp_out to out is
//    1 cycle.
//  - DRAIN -> STATUS once out_cnt==N_OUT. If N_OUT is reached during LOAD, DRAIN exits on
//    its first cycle.
//  - Watchdog: in DRAIN, a counter increments each cycle with no result transfer and resets
//    on a transfer. When it reaches TIMEOUT, set err_tmo and go to STATUS.
//  - STATUS: load status word {8'hA5, 6'b0, err_tmo, err_hdr, frame_count_next[15:0]} into
//    the output register when it is free. Then frame_count++ (including on error), clear
//    error flags and go to IDLE.
//  - No frame pipelining: a new header is accepted only in IDLE.
// STRUCTURE
//  - Package img_seq_pkg: state_t enum {IDLE,HDR1,LOAD,DRAIN,STATUS}, STATUS_MAGIC=8'hA5,
//    ERR_HDR_BIT=16, ERR_TMO_BIT=17, and the header field slice localparams.
//  - Sub-module img_seq_out_reg: the 1-entry output register/stall logic (reusable).
//  - Counters in the top: in_cnt 32b, out_cnt 32b, wdog $clog2(TIMEOUT+1), frame_count 16b.
// TESTING
//  1. Header {4,4}, N_OUT=4, 4 payload words, preproc echoes each word: 4 words pass
//     through, then A500_0001; busy=0, frame_count=1.
//  2. Header {3,1}, N_OUT=1: N_IN=1 (ceil 3/4). The second host word is stalled until the
//     status word A500_0001 is emitted.
//  3. Header {0,5}: no pp_in_valid; out = A501_0001 (err_hdr); next header is accepted.
//  4. Header {4,4}, N_OUT=2, preproc silent after 1 result: TIMEOUT cycles later
//     out = A502_0001.
//  5. downstream_stall held for 10 cycles with a result pending: out_data stays stable,
//     pp_out_stall=1, no word lost or duplicated. Random stall patterns on all 3 links
//     give a correct count.
//  6. Assert reset mid-LOAD: all outputs return to 0 immediately, and no status word is
//     sent. The next clean frame reports frame_count 1.

Source files
------------

// File: rtl/img_seq_pkg.sv
// Shared types and constants for the frame sequencer: FSM states, header field
// positions and the layout of the end-of-frame status word.
package img_seq_pkg;

  typedef enum logic [2:0] {IDLE, HDR1, LOAD, DRAIN, STATUS} state_t;

  localparam logic [7:0] STATUS_MAGIC = 8'hA5;
  localparam int ERR_HDR_BIT = 16;
  localparam int ERR_TMO_BIT = 17;

  localparam int HDR_W_MSB = 31;
  localparam int HDR_W_LSB = 16;
  localparam int HDR_H_MSB = 15;
  localparam int HDR_H_LSB = 0;

  function automatic logic [31:0] status_word(input logic err_tmo, input logic err_hdr,
                                              input logic [15:0] fc);
    logic [31:0] w;
    w = {STATUS_MAGIC, 8'h00, fc};
    w[ERR_HDR_BIT] = err_hdr;
    w[ERR_TMO_BIT] = err_tmo;
    return w;
  endfunction

endpackage

// File: rtl/img_seq_out_reg.sv
// One-entry output register: accepts a new word whenever it is empty or its
// current word is leaving this cycle.
module img_seq_out_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         downstream_stall
);

  assign load_ready = !(out_valid && downstream_stall);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_ready) begin
      out_valid <= load_valid;
      if (load_valid) out_data <= load_data;
    end
  end

endmodule

// File: rtl/img_frame_sequencer.sv
// Frame controller in front of the preprocessor: parses the 2-word header, meters
// payload in, forwards N_OUT results and closes each frame with a status word.
module img_frame_sequencer
  import img_seq_pkg::*;
#(
  parameter int PIX_PER_WORD = 4,
  parameter int MAX_WORDS    = 65536,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        upstream_stall,
  output logic [31:0] pp_in_data,
  output logic        pp_in_valid,
  input  logic        pp_in_stall,
  input  logic [31:0] pp_out_data,
  input  logic        pp_out_valid,
  output logic        pp_out_stall,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        downstream_stall,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int PPW_SH = $clog2(PIX_PER_WORD);
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [15:0]       hdr_w, hdr_h;
  logic [31:0]       n_in, n_out, in_cnt, out_cnt;
  logic [WD_W-1:0]   wdog;
  logic              err_hdr, err_tmo;

  logic [31:0] pix, n_in_calc;
  logic        hdr_bad, in_xfer, res_en, res_xfer, ld_ready, ld_valid;
  logic [31:0] ld_data;

  // Ceiling divide without a 33b add: shift, then round up on any leftover pixels.
  assign pix       = 32'(hdr_w) * 32'(hdr_h);
  assign n_in_calc = (pix >> PPW_SH) + 32'((pix & 32'(PIX_PER_WORD - 1)) != 32'd0);
  assign hdr_bad   = (hdr_w == 16'd0) || (hdr_h == 16'd0) ||
                     (n_in_calc > 32'(MAX_WORDS)) || (in_data == 32'd0);

  always_comb begin
    upstream_stall = 1'b1;
    case (state)
      IDLE, HDR1: upstream_stall = 1'b0;
      LOAD:       upstream_stall = pp_in_stall;
      default:    upstream_stall = 1'b1;
    endcase
  end

  assign pp_in_data  = in_data;
  assign pp_in_valid = (state == LOAD) && in_valid;
  assign in_xfer     = in_valid && !upstream_stall;
  assign busy        = (state != IDLE);

  assign res_en       = ((state == LOAD) || (state == DRAIN)) && (out_cnt < n_out);
  assign pp_out_stall = !res_en || !ld_ready;
  assign res_xfer     = pp_out_valid && !pp_out_stall;

  // The status word shares the output register; results are never enabled in STATUS.
  assign ld_valid = (state == STATUS) || res_xfer;
  assign ld_data  = (state == STATUS) ? status_word(err_tmo, err_hdr, frame_count + 16'd1)
                                      : pp_out_data;

  img_seq_out_reg #(.W(32)) u_out_reg (
    .clock            (clock),
    .reset            (reset),
    .load_data        (ld_data),
    .load_valid       (ld_valid),
    .load_ready       (ld_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .downstream_stall (downstream_stall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hdr_w       <= '0;
      hdr_h       <= '0;
      n_in        <= '0;
      n_out       <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wdog        <= '0;
      err_hdr     <= 1'b0;
      err_tmo     <= 1'b0;
      frame_count <= '0;
    end else begin
      if (res_xfer) out_cnt <= out_cnt + 32'd1;
      case (state)
        IDLE: if (in_xfer) begin
          hdr_w <= in_data[HDR_W_MSB:HDR_W_LSB];
          hdr_h <= in_data[HDR_H_MSB:HDR_H_LSB];
          state <= HDR1;
        end
        HDR1: if (in_xfer) begin
          n_out   <= in_data;
          n_in    <= n_in_calc;
          in_cnt  <= '0;
          out_cnt <= '0;
          if (hdr_bad) begin
            err_hdr <= 1'b1;
            state   <= STATUS;
          end else begin
            state   <= LOAD;
          end
        end
        LOAD: if (in_xfer) begin
          in_cnt <= in_cnt + 32'd1;
          if (in_cnt + 32'd1 == n_in) begin
            wdog  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_cnt == n_out) state <= STATUS;
          else if (res_xfer) wdog <= '0;
          else if (wdog == WD_W'(TIMEOUT - 1)) begin
            err_tmo <= 1'b1;
            state   <= STATUS;
          end else wdog <= wdog + 1'b1;
        end
        STATUS: if (ld_ready) begin
          frame_count <= frame_count + 16'd1;
          err_hdr     <= 1'b0;
          err_tmo     <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Directed bench for img_frame_sequencer with an echoing preprocessor model and
// an output collector; every step checks against hand-computed words.
module tb_img_frame_sequencer;

  localparam int PPW  = 4;
  localparam int MAXW = 64;
  localparam int TMO  = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        upstream_stall;
  logic [31:0] pp_in_data;
  logic        pp_in_valid;
  logic        pp_in_stall = 1'b0;
  logic [31:0] pp_out_data = '0;
  logic        pp_out_valid = 1'b0;
  logic        pp_out_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        downstream_stall = 1'b0;
  logic        busy;
  logic [15:0] frame_count;

  img_frame_sequencer #(.PIX_PER_WORD(PPW), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .upstream_stall(upstream_stall), .pp_in_data(pp_in_data), .pp_in_valid(pp_in_valid),
    .pp_in_stall(pp_in_stall), .pp_out_data(pp_out_data), .pp_out_valid(pp_out_valid),
    .pp_out_stall(pp_out_stall), .out_data(out_data), .out_valid(out_valid),
    .downstream_stall(downstream_stall), .busy(busy), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int compared = 0, mismatched = 0;
  int cyc = 0;
  logic [31:0] got[$];
  int          got_t[$];
  int          ppin_cnt = 0;

  bit ds_force = 0, rand_mode = 0, pp_flush = 0;
  int pp_limit = 1000000;
  int pp_emit = 0;
  logic [31:0] pp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && out_valid && !downstream_stall) begin
      got.push_back(out_data);
      got_t.push_back(cyc);
    end
    if (pp_in_valid) ppin_cnt++;
  end

  // Echoing preprocessor: each payload word comes back as one result word.
  always @(posedge clock) begin
    if (pp_out_valid && !pp_out_stall) begin
      void'(pp_q.pop_front());
      pp_emit++;
    end
    if (pp_in_valid && !pp_in_stall) pp_q.push_back(pp_in_data);
    if (pp_flush) begin
      pp_q.delete();
      pp_emit = 0;
    end
    pp_out_valid     <= (pp_q.size() > 0) && (pp_emit < pp_limit) &&
                        !(rand_mode && $urandom_range(3) == 0);
    pp_out_data      <= (pp_q.size() > 0) ? pp_q[0] : 32'd0;
    pp_in_stall      <= rand_mode && ($urandom_range(2) == 0);
    downstream_stall <= ds_force || (rand_mode && ($urandom_range(2) == 0));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timed_out(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic send(input logic [31:0] d, output int stalls);
    bit done = 0;
    stalls = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 400 && !done; n++) begin
      #1;
      if (!upstream_stall) begin
        @(posedge clock);
        done = 1;
      end else begin
        stalls++;
        @(negedge clock);
      end
    end
    #1 in_valid = 1'b0;
    if (!done) timed_out("send");
  endtask

  task automatic wait_got(input int n, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clock);
      if (got.size() >= n) ok = 1;
    end
    if (!ok) timed_out("wait_out");
  endtask

  task automatic flush_pp();
    @(negedge clock) pp_flush = 1;
    @(negedge clock) pp_flush = 0;
  endtask

  initial begin
    int s, s2, base, p0, t0, nb;
    logic [31:0] d0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pp_in_valid", {31'd0, pp_in_valid}, 32'd0);
    chk("rst_upstream_stall", {31'd0, upstream_stall}, 32'd0);
    @(negedge clock) reset = 0;

    // Frame 1: 4x4, 4 words echoed, then status
    base = got.size();
    send(32'h0004_0004, s);
    chk("f1_busy_hdr", {31'd0, busy}, 32'd1);
    send(32'd4, s);
    for (int i = 0; i < 4; i++) send(32'h11 * (i + 1), s);
    wait_got(base + 5, 100);
    for (int i = 0; i < 4; i++) chk("f1_result", got[base+i], 32'h11 * (i + 1));
    chk("f1_status", got[base+4], 32'hA500_0001);
    repeat (2) @(negedge clock);
    chk("f1_busy_idle", {31'd0, busy}, 32'd0);
    chk("f1_frame_count", {16'd0, frame_count}, 32'd1);

    // Frame 2: 3x1 rounds up to 1 word; next header held off until status is out
    base = got.size();
    send(32'h0003_0001, s);
    send(32'd1, s);
    send(32'h0000_ABCD, s);
    send(32'h0000_0005, s2);
    chk("f2_next_hdr_stalled", 32'(s2 > 0), 32'd1);
    chk("f2_out_count", got.size(), base + 2);
    chk("f2_result", got[base], 32'h0000_ABCD);
    chk("f2_status", got[base+1], 32'hA500_0002);

    // Frame 3: header {0,5} rejected, no payload reaches the preprocessor
    base = base + 2;
    p0 = ppin_cnt;
    send(32'd3, s);
    wait_got(base + 1, 50);
    chk("f3_status_err_hdr", got[base], 32'hA501_0003);
    repeat (2) @(negedge clock);
    chk("f3_no_pp_in", ppin_cnt, p0);

    // Oversize (32x16 = 128 words > 64) and N_OUT == 0 rejections
    base = got.size();
    send(32'h0020_0010, s);
    send(32'd1, s);
    wait_got(base + 1, 50);
    chk("oversize_status", got[base], 32'hA501_0004);
    base = got.size();
    send(32'h0001_0001, s);
    send(32'd0, s);
    wait_got(base + 1, 50);
    chk("nout0_status", got[base], 32'hA501_0005);
    chk("rej_no_pp_in", ppin_cnt, p0);

    // Frame: preprocessor goes silent after one result -> watchdog
    pp_limit = 1;
    flush_pp();
    base = got.size();
    send(32'h0004_0004, s);
    send(32'd2, s);
    for (int i = 0; i < 4; i++) send(32'h100 + i, s);
    @(negedge clock) t0 = cyc;
    wait_got(base + 2, TMO + 40);
    chk("tmo_result", got[base], 32'h0000_0100);
    chk("tmo_status", got[base+1], 32'hA502_0006);
    chk("tmo_latency", 32'(got_t[base+1] - t0), 32'(TMO + 1));
    pp_limit = 1000000;
    flush_pp();

    // Frame: downstream stalled for 10 cycles with a result pending
    @(negedge clock) ds_force = 1;
    base = got.size();
    send(32'h0004_0002, s);
    send(32'd2, s);
    send(32'h201, s);
    send(32'h202, s);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
    d0 = out_data;
    chk("hold_first", d0, 32'h201);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_data", out_data, 32'h201);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_pp_out_stall", {31'd0, pp_out_stall}, 32'd1);
    end
    ds_force = 0;
    wait_got(base + 3, 50);
    repeat (5) @(negedge clock);
    chk("hold_count", got.size(), base + 3);
    chk("hold_r0", got[base], 32'h201);
    chk("hold_r1", got[base+1], 32'h202);
    chk("hold_status", got[base+2], 32'hA500_0007);

    // Frame: 16x16 = 64 words (exactly MAX_WORDS) under random stalls on all links
    flush_pp();
    rand_mode = 1;
    base = got.size();
    send(32'h0010_0010, s);
    send(32'd64, s);
    for (int i = 0; i < 64; i++) send(32'(i * 7 + 1), s);
    wait_got(base + 65, 3000);
    for (int i = 0; i < 64; i++) chk("rand_result", got[base+i], 32'(i * 7 + 1));
    chk("rand_status", got[base+64], 32'hA500_0008);
    rand_mode = 0;
    repeat (5) @(negedge clock);
    chk("rand_count", got.size(), base + 65);

    // Reset in the middle of LOAD drops the frame silently
    flush_pp();
    send(32'h0004_0004, s);
    send(32'd4, s);
    send(32'h301, s);
    send(32'h302, s);
    @(negedge clock);
    chk("mid_busy_load", {31'd0, busy}, 32'd1);
    nb = got.size();
    in_valid = 1;
    in_data  = 32'h303;
    reset    = 1;
    pp_flush = 1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("mid_rst_pp_in_valid", {31'd0, pp_in_valid}, 32'd0);
    in_valid = 0;
    @(negedge clock);
    @(negedge clock) begin reset = 0; pp_flush = 0; end
    repeat (10) @(negedge clock);
    chk("mid_rst_no_status", got.size(), nb);
    base = got.size();
    send(32'h0004_0001, s);
    send(32'd1, s);
    send(32'h401, s);
    wait_got(base + 2, 50);
    chk("post_rst_result", got[base], 32'h401);
    chk("post_rst_status", got[base+1], 32'hA500_0001);
    repeat (2) @(negedge clock);
    chk("post_rst_frame_count", {16'd0, frame_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
